// File: rtl/axi_pkg.sv
// Shared AXI definitions used by the FIFO master and the FIFO slave.
package axi_pkg;
    localparam logic [2:0] SIZE_4B     = 3'b010;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA
    } state_e;
endpackage

// File: rtl/axi_fifo_master_if.sv
// AXI4 write/response/read channel bundle between the FIFO master and the FIFO slave.
interface axi_fifo_master_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
);
    logic                    awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic                    bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_fifo_master.sv
// Command-driven AXI4 master: each command becomes one INCR burst of 32-bit beats,
// with write beats taken from a local stream and read beats returned on another.
module axi_fifo_master
    import axi_pkg::*;
#(
    parameter int   ADDR_WIDTH = 6,
    parameter int   DATA_WIDTH = 32,
    parameter logic TXN_ID     = 1'b1
) (
    input  logic                  m00_axi_aclk,
    input  logic                  m00_axi_aresetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_last,
    input  logic                  rd_ready,
    output logic                  done,
    output logic                  err,
    axi_fifo_master_if.master     m00_axi
);
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;
    logic                  err_acc_q, err_acc_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic in_wdata, in_rdata, last_beat, w_hs, r_hs, b_err, r_err;

    assign in_wdata  = (state_q == WR_DATA);
    assign in_rdata  = (state_q == RD_DATA);
    assign last_beat = (beat_cnt_q == len_q);
    assign w_hs      = in_wdata && wr_valid && m00_axi.wready;
    assign r_hs      = in_rdata && m00_axi.rvalid && rd_ready;
    assign b_err     = (m00_axi.bresp != RESP_OKAY) || (m00_axi.bid != TXN_ID);
    // The burst ends on our own beat count; a misplaced rlast is only flagged.
    assign r_err     = (m00_axi.rresp != RESP_OKAY) || (m00_axi.rlast != last_beat);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        err_acc_d  = err_acc_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d     = cmd_addr;
                    len_d      = cmd_len;
                    beat_cnt_d = 8'd0;
                    err_acc_d  = 1'b0;
                    state_d    = cmd_write ? WR_ADDR : RD_ADDR;
                end
            end
            WR_ADDR: if (m00_axi.awready) state_d = WR_DATA;
            WR_DATA: begin
                if (w_hs) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (last_beat) state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (m00_axi.bvalid) begin
                    err_acc_d = err_acc_q | b_err;
                    done_d    = 1'b1;
                    err_d     = err_acc_d;
                    state_d   = IDLE;
                end
            end
            RD_ADDR: if (m00_axi.arready) state_d = RD_DATA;
            RD_DATA: begin
                if (r_hs) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    err_acc_d  = err_acc_q | r_err;
                    if (last_beat) begin
                        done_d  = 1'b1;
                        err_d   = err_acc_d;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
            err_acc_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
            err_acc_q  <= err_acc_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign done      = done_q;
    assign err       = err_q;

    // AXI valids come straight from the state register, never from a ready.
    assign m00_axi.awid    = TXN_ID;
    assign m00_axi.awaddr  = addr_q;
    assign m00_axi.awlen   = len_q;
    assign m00_axi.awsize  = SIZE_4B;
    assign m00_axi.awburst = BURST_INCR;
    assign m00_axi.awvalid = (state_q == WR_ADDR);

    assign m00_axi.wdata   = in_wdata ? wr_data : '0;
    assign m00_axi.wstrb   = in_wdata ? '1 : '0;
    assign m00_axi.wlast   = in_wdata && last_beat;
    assign m00_axi.wvalid  = in_wdata && wr_valid;
    assign wr_ready        = in_wdata && m00_axi.wready;

    assign m00_axi.bready  = (state_q == WR_RESP);

    assign m00_axi.araddr  = addr_q;
    assign m00_axi.arlen   = len_q;
    assign m00_axi.arsize  = SIZE_4B;
    assign m00_axi.arburst = BURST_INCR;
    assign m00_axi.arvalid = (state_q == RD_ADDR);

    assign rd_data         = in_rdata ? m00_axi.rdata : '0;
    assign rd_valid        = in_rdata && m00_axi.rvalid;
    assign rd_last         = in_rdata && m00_axi.rlast;
    assign m00_axi.rready  = in_rdata && rd_ready;
endmodule

// File: tb/tb_axi_fifo_master.sv
// Directed bench for axi_fifo_master: a procedural AXI slave plus stream source/sink,
// with expected beats queued at stimulus time and compared as the DUT emits them.
module tb_axi_fifo_master;
    import axi_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [5:0]  cmd_addr;
    logic [7:0]  cmd_len;
    logic [31:0] wr_data, rd_data;
    logic        wr_valid, wr_ready, rd_valid, rd_last, rd_ready;
    logic        done, err;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] src [256];
    logic [31:0] exp_w_q [$];
    logic [32:0] exp_r_q [$];

    axi_fifo_master_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) axi ();

    axi_fifo_master #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .TXN_ID(1'b1)) dut (
        .m00_axi_aclk    (clk),
        .m00_axi_aresetn (rst_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_write       (cmd_write),
        .cmd_addr        (cmd_addr),
        .cmd_len         (cmd_len),
        .wr_data         (wr_data),
        .wr_valid        (wr_valid),
        .wr_ready        (wr_ready),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .rd_last         (rd_last),
        .rd_ready        (rd_ready),
        .done            (done),
        .err             (err),
        .m00_axi         (axi)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;
        axi.awready = 1'b0; axi.wready = 1'b0;
        axi.bid = 1'b0; axi.bresp = 2'b00; axi.bvalid = 1'b0;
        axi.arready = 1'b0; axi.rdata = '0; axi.rresp = 2'b00;
        axi.rlast = 1'b0; axi.rvalid = 1'b0;
    endtask

    task automatic fill_src(input logic [31:0] seed);
        for (int i = 0; i < 256; i++) src[i] = seed ^ {i[7:0], ~i[7:0], i[7:0], 8'h5A};
    endtask

    task automatic issue_cmd(input string tag, input logic wr, input logic [5:0] a, input logic [7:0] l);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l;
        #1 check({tag, " cmd_ready"}, 64'(cmd_ready), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic finish_cmd(input string tag, input int cyc, input int exp_cyc, input logic exp_err);
        check({tag, " done_seen"}, 64'(done), 64'd1);
        check({tag, " err"}, 64'(err), 64'(exp_err));
        if (exp_cyc > 0) check({tag, " latency"}, 64'(cyc), 64'(exp_cyc));
        @(negedge clk);
        check({tag, " done_pulse"}, 64'({done, cmd_ready}), 64'b01);
    endtask

    // abort_at >= 0: pull reset while the beat with that index is being offered.
    task automatic run_write(input string tag, input logic [5:0] a, input logic [7:0] l,
                             input int aw_wait, input int w_wait, input bit wv_gap,
                             input logic [1:0] br, input logic bid_v, input logic exp_err,
                             input int exp_cyc, input int abort_at);
        int cyc, beat, aw_cnt, stall;
        bit w_done;
        exp_w_q.delete();
        for (int i = 0; i <= int'(l); i++) exp_w_q.push_back(src[i]);
        issue_cmd(tag, 1'b1, a, l);
        cyc = 1; beat = 0; aw_cnt = 0; stall = 0; w_done = 1'b0;
        while (done !== 1'b1 && cyc < 1000) begin
            wr_valid   = !(wv_gap && (cyc % 3 == 0));
            wr_data    = (beat <= int'(l)) ? src[beat] : 32'h0;
            axi.bvalid = w_done; axi.bresp = br; axi.bid = bid_v;
            if (axi.awvalid) begin
                check({tag, " awaddr"}, 64'(axi.awaddr), 64'(a));
                check({tag, " awlen"}, 64'(axi.awlen), 64'(l));
                check({tag, " aw_size_burst_id"}, 64'({axi.awsize, axi.awburst, axi.awid}), 64'({SIZE_4B, BURST_INCR, 1'b1}));
                axi.awready = (aw_cnt >= aw_wait);
                aw_cnt++;
            end else axi.awready = 1'b0;
            #1;
            if (!wr_valid) check({tag, " wvalid_gap"}, 64'(axi.wvalid), 64'd0);
            axi.wready = axi.wvalid && (stall >= w_wait);
            #1;
            if (abort_at >= 0 && beat == abort_at && axi.wvalid) begin
                rst_n = 1'b0;
                #1 check({tag, " valids_in_reset"},
                         64'({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready,
                              wr_ready, rd_valid, done, cmd_ready}), 64'b000000001);
                idle_inputs();
                exp_w_q.delete();
                return;
            end
            if (axi.wvalid && axi.wready) begin
                check({tag, " wr_ready"}, 64'(wr_ready), 64'd1);
                check({tag, " w_beat_expected"}, 64'(exp_w_q.size() > 0), 64'd1);
                if (exp_w_q.size() > 0) check({tag, " wdata"}, 64'(axi.wdata), 64'(exp_w_q.pop_front()));
                check({tag, " wlast_strb"}, 64'({axi.wlast, axi.wstrb}), 64'({beat == int'(l), 4'hF}));
                if (beat == int'(l)) w_done = 1'b1;
                beat++;
                stall = 0;
            end else if (axi.wvalid) stall++;
            if (axi.bvalid && axi.bready) w_done = 1'b0;
            @(negedge clk);
            cyc++;
        end
        idle_inputs();
        check({tag, " beats"}, 64'(beat), 64'(int'(l) + 1));
        finish_cmd(tag, cyc, exp_cyc, exp_err);
    endtask

    task automatic run_read(input string tag, input logic [5:0] a, input logic [7:0] l,
                            input int ar_wait, input bit rr_toggle, input int last_at,
                            input logic [1:0] rr, input logic exp_err, input int exp_cyc);
        int cyc, rbeat, ar_cnt, got;
        bit ar_done;
        logic [32:0] exp_beat;
        exp_r_q.delete();
        for (int i = 0; i <= int'(l); i++) exp_r_q.push_back({i == last_at, src[i]});
        issue_cmd(tag, 1'b0, a, l);
        cyc = 1; rbeat = 0; ar_cnt = 0; got = 0; ar_done = 1'b0;
        while (done !== 1'b1 && cyc < 1000) begin
            rd_ready = rr_toggle ? (cyc % 2 == 1) : 1'b1;
            if (axi.arvalid) begin
                check({tag, " araddr"}, 64'(axi.araddr), 64'(a));
                check({tag, " arlen"}, 64'(axi.arlen), 64'(l));
                check({tag, " ar_size_burst"}, 64'({axi.arsize, axi.arburst}), 64'({SIZE_4B, BURST_INCR}));
                axi.arready = (ar_cnt >= ar_wait);
                ar_cnt++;
            end else axi.arready = 1'b0;
            axi.rvalid = ar_done && (rbeat <= int'(l));
            axi.rdata  = axi.rvalid ? src[rbeat] : 32'h0;
            axi.rlast  = axi.rvalid && (rbeat == last_at);
            axi.rresp  = rr;
            #1;
            if (!rd_ready) check({tag, " rready_gated"}, 64'(axi.rready), 64'd0);
            if (axi.rvalid) check({tag, " rd_valid"}, 64'(rd_valid), 64'd1);
            if (rd_valid && rd_ready) begin
                check({tag, " r_beat_expected"}, 64'(exp_r_q.size() > 0), 64'd1);
                if (exp_r_q.size() > 0) begin
                    exp_beat = exp_r_q.pop_front();
                    check({tag, " rd_last_data"}, 64'({rd_last, rd_data}), 64'(exp_beat));
                end
                got++;
            end
            if (axi.rvalid && axi.rready) rbeat++;
            if (axi.arvalid && axi.arready) ar_done = 1'b1;
            @(negedge clk);
            cyc++;
        end
        idle_inputs();
        check({tag, " beats"}, 64'(got), 64'(int'(l) + 1));
        finish_cmd(tag, cyc, exp_cyc, exp_err);
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset ctrl", 64'({cmd_ready, axi.awvalid, axi.wvalid, axi.bready, axi.arvalid,
                                 axi.rready, wr_ready, rd_valid, done, err}), 64'b1000000000);
        check("reset addr_len", 64'({axi.awaddr, axi.araddr, axi.awlen, axi.arlen}), 64'd0);
        check("reset data", 64'({axi.wdata, rd_data}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        src[0] = 32'hAAAAAAAA;
        run_write("single_wr", 6'h04, 8'd0, 0, 0, 1'b0, RESP_OKAY, 1'b1, 1'b0, 4, -1);

        src[0] = 32'hABABABAB; src[1] = 32'hCDCDCDCD; src[2] = 32'hEFEFEFEF; src[3] = 32'h01010101;
        run_write("burst_wr", 6'h10, 8'd3, 2, 2, 1'b1, RESP_OKAY, 1'b1, 1'b0, 0, -1);

        src[0] = 32'hAAAAAAAA; src[1] = 32'hBBBBBBBB;
        run_read("rd_toggle", 6'h04, 8'd1, 1, 1'b1, 1, RESP_OKAY, 1'b0, 0);
        run_read("rd_min", 6'h08, 8'd0, 0, 1'b0, 0, RESP_OKAY, 1'b0, 3);

        run_write("bresp_err", 6'h0C, 8'd0, 0, 0, 1'b0, RESP_SLVERR, 1'b1, 1'b1, 4, -1);
        run_write("bid_err", 6'h0C, 8'd1, 0, 0, 1'b0, RESP_OKAY, 1'b0, 1'b1, 5, -1);
        run_write("ok_after_err", 6'h14, 8'd0, 0, 0, 1'b0, RESP_OKAY, 1'b1, 1'b0, 4, -1);

        src[2] = 32'hCCCCCCCC;
        run_read("rlast_early", 6'h20, 8'd2, 0, 1'b0, 1, RESP_OKAY, 1'b1, 5);
        run_read("rresp_err", 6'h24, 8'd0, 0, 1'b0, 0, RESP_SLVERR, 1'b1, 3);

        fill_src(32'h1234_0000);
        run_write("abort_wr", 6'h30, 8'd3, 0, 1, 1'b0, RESP_OKAY, 1'b1, 1'b0, 0, 2);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check("post_reset idle", 64'({cmd_ready, axi.awvalid, axi.wvalid, axi.arvalid, done}), 64'b10000);
        run_write("after_rst", 6'h34, 8'd1, 0, 0, 1'b0, RESP_OKAY, 1'b1, 1'b0, 5, -1);

        fill_src(32'hC0DE_0000);
        run_read("len255_rd", 6'h3C, 8'd255, 0, 1'b0, 255, RESP_OKAY, 1'b0, 258);
        run_write("len255_wr", 6'h00, 8'd255, 0, 0, 1'b0, RESP_OKAY, 1'b1, 1'b0, 259, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/axi_fifo_master.md
# axi_fifo_master

AXI4 full master engine that drives the write, write-response, read-address and read-data channels of the team's AXI FIFO slave. It replaces hand-sequenced bus stimulus with a command port.
- Each accepted command becomes exactly one INCR burst of 32-bit beats.
- Write beats are sourced from a local stream and read beats are returned on a local stream.
- The block sits between system logic or the AES datapath and the AXI FIFO IP.

## Interface
- ADDR_WIDTH, 6, AXI address width (byte address).
- DATA_WIDTH, 32, AXI data width; fixed at 32 (awsize/arsize = 3'b010).
- TXN_ID, 1'b1, value driven on awid; bid is checked against it.
- m00_axi_aclk  in  1  single clock, all logic rising-edge.
- m00_axi_aresetn  in  1  reset, asynchronous assert, active-low.
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_WIDTH  start address.
- cmd_len  in  8  beats minus 1 (AXI len encoding).
- wr_data / wr_valid / wr_ready  in / in / out  32 / 1 / 1  write beat stream.
- rd_data / rd_valid / rd_last / rd_ready  out / out / out / in  32 / 1 / 1 / 1  read beat stream.
- done  out  1  one-cycle pulse when a command completes.
- err  out  1  qualified by done; set if any response was non-OKAY, bid mismatched, or rlast was misplaced.
- m00_axi_awid, awaddr, awlen, awsize, awburst, awvalid / awready  out x6 / in  1, ADDR_WIDTH, 8, 3, 2, 1 / 1.
- m00_axi_wdata, wstrb, wlast, wvalid / wready  out x4 / in  32, 4, 1, 1 / 1.
- m00_axi_bid, bresp, bvalid / bready  in x3 / out  1, 2, 1 / 1.
- m00_axi_araddr, arlen, arsize, arburst, arvalid / arready  out x5 / in  ADDR_WIDTH, 8, 3, 2, 1 / 1.
- m00_axi_rdata, rresp, rlast, rvalid / rready  in x4 / out  32, 2, 1, 1 / 1.

## Operation
- States: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA.
- IDLE: cmd_ready = 1.
  - On cmd_valid, register addr, len and write, clear the beat counter and err_acc.
  - Go to WR_ADDR if cmd_write, otherwise RD_ADDR.
- WR_ADDR: awvalid = 1 with the registered fields, awsize = 3'b010, awburst = 2'b01, awid = TXN_ID.
  - All AW fields are held stable until awready; the AW handshake moves to WR_DATA.
- WR_DATA: wvalid = wr_valid, wdata = wr_data, wr_ready = wready, wstrb = 4'hF, wlast = (beat_cnt == len).
  - Each handshake increments beat_cnt (8-bit).
  - The handshake with wlast moves to WR_RESP.
- WR_RESP: bready = 1.
  - On bvalid, err_acc |= (bresp != 0) | (bid != TXN_ID), then go to IDLE.
  - done pulses in the same cycle as the state return.
- RD_ADDR: arvalid = 1, arlen = len, arsize = 3'b010, arburst = 2'b01; held until arready, then RD_DATA.
- RD_DATA: rd_valid = rvalid, rd_data = rdata, rd_last = rlast, rready = rd_ready.
  - Each handshake increments beat_cnt and does err_acc |= (rresp != 0) | (rlast != (beat_cnt == len)).
  - The handshake where beat_cnt == len ends the burst regardless of rlast: go to IDLE and pulse done.
- Stream outputs are idle when not in the owning state:
  - wr_ready = 0 outside WR_DATA.
  - rd_valid = 0 outside RD_DATA.
- No write/read overlap: one outstanding transaction at a time.

## Timing
- Reset values: every valid/ready output is 0, except cmd_ready = 1 (state IDLE). done = 0, err = 0. All address/len/data outputs are 0.
- Reset mid-burst aborts immediately (async). No beats are replayed.
- Command accepted at edge N: awvalid or arvalid is high from cycle N+1.
- AXI valids never depend combinationally on the matching AXI ready.
- wvalid follows wr_valid combinationally, as does rready with rd_ready. No stream buffering.
- Minimum write latency, zero-wait slave, len = 0: cmd → AW → W → B → done in 4 cycles.
- Minimum read latency: cmd → AR → R → done in 3 cycles.
- A new cmd_valid is accepted at the earliest in the cycle after done.
- Zero-wait bursts sustain 1 beat per cycle.
- len = 255: beat_cnt reaches 255 with no wrap before termination.
- Address width: awaddr/araddr pass through; the block performs no 4 KB boundary check.

## Structure
- Shared package (axi_pkg), also used by the FIFO slave, holds:
  - SIZE_4B = 3'b010
  - BURST_INCR = 2'b01
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10
  - the state enum
- Single module; no sub-module required. An optional axi_master_fsm split is not needed at this size.

## Test plan
- Single write: cmd (write, 0x04, len 0) with wr_data 0xAAAAAAAA and a zero-wait slave → awaddr 0x04, one beat with wlast = 1, done at cycle 4, err = 0.
- Burst write: len 3 with data 0xABABABAB, 0xCDCDCDCD, 0xEFEFEFEF, 0x01010101; slave holds wready low 2 cycles per beat → 4 beats in order, wlast only on the 4th, AW fields stable while awready is low.
- Read: cmd (read, 0x04, len 1) with slave returning 0xAAAAAAAA and 0xBBBBBBBB, rd_ready toggling → rd_data sequence intact, rd_last on the 2nd beat, done with err = 0.
- Error: slave returns bresp = 2'b10 → done with err = 1. A read whose rlast arrives on beat 1 of len 2 → err = 1, burst completes after 3 beats.
- Reset: assert aresetn low during beat 2 of a write burst → all valids 0 within the same cycle, cmd_ready = 1 after release, next command runs normally.
